i_cache_axi_rd: RTL

Refill responder for the instruction cache: accepts the cache's single-beat refill request (`cache_read_ena`/`cache_addr`) and returns one 64-bit doubleword (`cache_or_data`) qualified by a one-cycle `cache_in_ok` pulse. It sits between the I-cache and the system AXI4 interconnect and acts as an AXI4 read master: one single-beat read transaction per request, no write channels. Only one transaction is outstanding at a time.

---
 rtl/i_cache_axi_rd.sv | 117 +++++++++++
 1 files changed

// File: rtl/i_cache_axi_rd.sv
// i_cache_axi_rd: refill responder for the instruction cache.
// It turns each single-beat I-cache refill request into one single-beat AXI4 read
// (INCR, 8 bytes, len 0). It returns the doubleword with a one-cycle cache_in_ok pulse.
// Only one transaction is ever outstanding, and there are no write channels.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   cache_read_ena, cache_addr    refill request (level) and byte address
//   cache_or_data, cache_in_ok    returned doubleword, one-cycle completion pulse
//   cache_rd_err                  completion carried a non-OKAY response
//   axi_ar_*                      AXI4 read address channel (master side)
//   axi_r_*                       AXI4 read data channel (master side)
module i_cache_axi_rd #(
  parameter int unsigned          AXI_ID_W = 4,
  parameter logic [AXI_ID_W-1:0]  AXI_ID   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cache_read_ena,
  input  logic [31:0]         cache_addr,
  output logic [63:0]         cache_or_data,
  output logic                cache_in_ok,
  output logic                cache_rd_err,
  output logic                axi_ar_valid,
  input  logic                axi_ar_ready,
  output logic [31:0]         axi_ar_addr,
  output logic [AXI_ID_W-1:0] axi_ar_id,
  output logic [7:0]          axi_ar_len,
  output logic [2:0]          axi_ar_size,
  output logic [1:0]          axi_ar_burst,
  input  logic                axi_r_valid,
  output logic                axi_r_ready,
  input  logic [63:0]         axi_r_data,
  input  logic [1:0]          axi_r_resp,
  input  logic                axi_r_last,
  input  logic [AXI_ID_W-1:0] axi_r_id
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StDone,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [28:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;

  // With a single outstanding beat, RID and RLAST add no information, and the
  // byte offset within the doubleword is dropped.
  logic unused_inputs;
  assign unused_inputs = ^{axi_r_last, axi_r_id, cache_addr[2:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cache_read_ena) begin
          addr_d  = cache_addr[31:3];
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (axi_ar_ready) state_d = StData;
      end
      StData: begin
        if (axi_r_valid) begin
          data_d  = axi_r_data;
          err_d   = (axi_r_resp != 2'b00);
          state_d = StDone;
        end
      end
      StDone: state_d = StHold;
      // A request still held high after completion must not start a second fetch.
      StHold: begin
        if (!cache_read_ena) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // All outputs come from state or registers only; no input reaches an output.
  always_comb begin
    axi_ar_valid  = (state_q == StAddr);
    axi_r_ready   = (state_q == StData);
    cache_in_ok   = (state_q == StDone);
    cache_rd_err  = (state_q == StDone) && err_q;
    cache_or_data = (state_q == StDone) ? data_q : 64'd0;
  end

  assign axi_ar_addr  = {addr_q, 3'b000};
  assign axi_ar_id    = AXI_ID;
  assign axi_ar_len   = 8'd0;
  assign axi_ar_size  = 3'b011;
  assign axi_ar_burst = 2'b01;

endmodule
